seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mul_seq.sv | 72 +++++++
 rtl/seq_alu.sv | 181 ++++++++++++++++++
 tb/tb_seq_alu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   alu_op_e    : 3-bit opcode encoding presented on the op port
//   alu_state_e : control FSM states
//   alu_flags_t : flag bundle registered alongside the result
//   calc_parity : even/odd parity helper (XOR reduction)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_MUL = 3'b110,
    OP_SHL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic parity;
    logic overflow;
  } alu_flags_t;

  // Zero-extension does not change the XOR reduction, so callers may pass
  // any result width up to 32 bits cast to 32 bits.
  function automatic logic calc_parity(input logic [31:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, one partial-product step per clock.
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : load a/b and begin a WIDTH-step multiplication
//   a, b       : unsigned multiplicand / multiplier
//   done       : high during the cycle whose closing edge performs the last step
//   product    : 2*WIDTH-bit product after the step taken on the coming edge;
//                equals the full product while done is high
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_step_s;

  assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // Exposing the post-step value lets the caller capture the product on the
  // same edge that performs the final step, saving a cycle of latency.
  assign done       = (cnt_q == CNT_W'(1));
  assign product    = acc_step_s;

  // Next-state for the operand shifters, accumulator and step counter.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = {(2*WIDTH){1'b0}};
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CNT_W'(WIDTH);
    end else if (cnt_q != CNT_W'(0)) begin
      acc_d    = acc_step_s;
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q - CNT_W'(1);
    end else begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
    end
  end

  // Multiplier state registers; reset clears the counter so an abandoned
  // multiplication never signals done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= {(2*WIDTH){1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes and registered result/flags.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid / in_ready : request handshake; a, b, op captured on acceptance
//   out_valid/out_ready : result handshake; result and flags hold until taken
//   result              : WIDTH-bit registered result
//   carry, zero, parity, overflow : registered flags matching result
// Single-cycle ops complete one cycle after acceptance; MUL runs the
// shift-add multiplier for WIDTH cycles and completes WIDTH+1 cycles after.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             parity,
  output logic             overflow
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  alu_flags_t         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [SH_W-1:0]    shamt_s;
  logic [2*WIDTH-1:0] shl_wide_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_carry_s;
  logic               alu_ovf_s;

  logic               mul_start_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_product_s;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .a       (a),
    .b       (b),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  assign sum_s      = {1'b0, a} + {1'b0, b};
  // The extra top bit of the difference is the unsigned borrow.
  assign diff_s     = {1'b0, a} - {1'b0, b};
  assign shamt_s    = b[SH_W-1:0];
  // Shifting into a double-width vector leaves the last bit shifted out at
  // position WIDTH (zero when the shift amount is zero).
  assign shl_wide_s = {{WIDTH{1'b0}}, a} << shamt_s;

  // Single-cycle ALU: result, carry and overflow for every non-MUL opcode.
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s   = diff_s[WIDTH-1:0];
        alu_carry_s = diff_s[WIDTH];
        alu_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res_s = a & b;
      OP_OR:   alu_res_s = a | b;
      OP_XOR:  alu_res_s = a ^ b;
      OP_NOT:  alu_res_s = ~a;
      OP_SHL: begin
        alu_res_s   = shl_wide_s[WIDTH-1:0];
        alu_carry_s = shl_wide_s[WIDTH];
      end
      OP_MUL: begin
        // Result comes from the multiplier; nothing to compute here.
        alu_res_s   = {WIDTH{1'b0}};
      end
      default: begin
        alu_res_s   = {WIDTH{1'b0}};
      end
    endcase
  end

  // Control FSM: acceptance, multiplier sequencing and output handshake.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    mul_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (alu_op_e'(op) == OP_MUL) begin
            mul_start_s = 1'b1;
            state_d     = ST_BUSY;
          end else begin
            state_d          = ST_DONE;
            result_d         = alu_res_s;
            flags_d.carry    = alu_carry_s;
            flags_d.zero     = (alu_res_s == {WIDTH{1'b0}});
            flags_d.parity   = calc_parity(32'(alu_res_s));
            flags_d.overflow = alu_ovf_s;
            out_valid_d      = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mul_done_s) begin
          state_d          = ST_DONE;
          result_d         = mul_product_s[WIDTH-1:0];
          flags_d.carry    = |mul_product_s[2*WIDTH-1:WIDTH];
          flags_d.zero     = (mul_product_s[WIDTH-1:0] == {WIDTH{1'b0}});
          flags_d.parity   = calc_parity(32'(mul_product_s[WIDTH-1:0]));
          flags_d.overflow = 1'b0;
          out_valid_d      = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        // Requests arriving here, including on the exit cycle, are dropped.
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= {WIDTH{1'b0}};
      flags_q     <= '{carry: 1'b0, zero: 1'b0, parity: 1'b0, overflow: 1'b0};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  // in_ready must be high on the very first edge after reset release, so it
  // is a decode of the state register gated by rst_n rather than its own flop.
  assign in_ready  = rst_n & (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign parity    = flags_q.parity;
  assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8) with a scoreboard queue.
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         parity;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       p;
    logic       v;
  } exp_t;

  exp_t sb_q[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .parity    (parity),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Reference model written from the opcode table, using integer arithmetic.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t        e;
    int          sx;
    int          sy;
    int          s;
    int          sh;
    int          ones;
    logic [15:0] p;
    e.res = 8'h00;
    e.c   = 1'b0;
    e.v   = 1'b0;
    sx    = $signed(x);
    sy    = $signed(y);
    case (o)
      3'd0: begin
        p = 16'(x) + 16'(y);
        e.res = p[7:0];
        e.c = p[8];
        s = sx + sy;
        e.v = (s > 127) || (s < -128);
      end
      3'd1: begin
        e.res = x - y;
        e.c = (x < y);
        s = sx - sy;
        e.v = (s > 127) || (s < -128);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = ~x;
      3'd6: begin
        p = 16'(x) * 16'(y);
        e.res = p[7:0];
        e.c = (p[15:8] != 8'h00);
      end
      default: begin
        sh = int'(y[2:0]);
        e.res = x << sh;
        e.c = (sh == 0) ? 1'b0 : x[8 - sh];
      end
    endcase
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(e.res[i]);
    e.p = ones[0];
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  // Issue one op (entered #1 after a rising edge), check it against the
  // scoreboard, optionally stall the output for 'hold' cycles while
  // throwing stray requests at the block, then complete the handshake.
  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input int hold);
    exp_t e;
    int   lat;
    check_val("in_ready_idle", 32'(in_ready), 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(model(o, x, y));
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", 32'(lat), (o == 3'd6) ? 32'd9 : 32'd1);
    check_val("sb_size", 32'(sb_q.size()), 32'd1);
    e = sb_q.pop_front();
    check_val("result", 32'(result), 32'(e.res));
    check_val("carry", 32'(carry), 32'(e.c));
    check_val("zero", 32'(zero), 32'(e.z));
    check_val("parity", 32'(parity), 32'(e.p));
    check_val("overflow", 32'(overflow), 32'(e.v));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk); #1;
      check_val("hold_result", 32'(result), 32'(e.res));
      check_val("hold_carry", 32'(carry), 32'(e.c));
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
      check_val("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_val("out_valid_drop", 32'(out_valid), 32'd0);
    if (hold > 0) begin
      @(posedge clk); #1;
      check_val("no_stray_accept", 32'(out_valid), 32'd0);
      check_val("stray_in_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; op = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_flags", 32'({carry, zero, parity, overflow}), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check_val("first_edge_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    do_op(3'd0, 8'hFF, 8'h01, 0);
    check_val("add_ff01", 32'({result, carry, zero, parity, overflow}), 32'({8'h00, 4'b1100}));
    do_op(3'd1, 8'h80, 8'h01, 0);
    check_val("sub_8001", 32'({result, carry, zero, parity, overflow}), 32'({8'h7F, 4'b0011}));
    do_op(3'd6, 8'h10, 8'h10, 0);
    check_val("mul_1010", 32'({result, carry, zero}), 32'({8'h00, 2'b11}));
    do_op(3'd6, 8'h0F, 8'h0F, 0);
    check_val("mul_0f0f", 32'({result, carry}), 32'({8'hE1, 1'b0}));
    do_op(3'd7, 8'h81, 8'h01, 0);
    check_val("shl_8101", 32'({result, carry}), 32'({8'h02, 1'b1}));
    do_op(3'd5, 8'h00, 8'h00, 0);
    check_val("not_00", 32'({result, parity, zero}), 32'({8'hFF, 2'b00}));
    do_op(3'd7, 8'hB5, 8'h00, 0);
    do_op(3'd0, 8'h7F, 8'h01, 0);

    do_op(3'd0, 8'h12, 8'h34, 5);

    for (int i = 0; i < 16; i++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0);
    end

    // Abort a multiply in its 4th busy cycle.
    do_op(3'd7, 8'h81, 8'h03, 0);
    op = 3'd6; a = 8'h10; b = 8'h10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", 32'(out_valid), 32'd0);
    check_val("abort_in_ready", 32'(in_ready), 32'd0);
    check_val("abort_result", 32'(result), 32'd0);
    check_val("abort_flags", 32'({carry, zero, parity, overflow}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check_val("abort_release_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check_val("abort_no_stale", 32'(seen), 32'd0);
    do_op(3'd0, 8'h03, 8'h04, 0);
    check_val("post_abort_add", 32'(result), 32'h07);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
